ff_bank: RTL

FF_BANK -- requirements
Module: ff_bank

---
 rtl/ff_pkg.sv | 43 ++++
 rtl/ff_cell.sv | 51 +++++
 rtl/ff_bank.sv | 81 ++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// Shared mode encoding and per-channel next-state helpers for the ff_bank flip-flop array.
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } ff_mode_e;

  // S=R=1 in SR mode is the only illegal operand combination.
  function automatic logic ff_invalid(input logic [1:0] mode, input logic a, input logic b);
    return (mode == MODE_SR) && a && b;
  endfunction

  function automatic logic ff_next(input logic [1:0] mode, input logic q, input logic a,
                                   input logic b);
    logic nxt;
    nxt = q;
    case (ff_mode_e'(mode))
      MODE_D:  nxt = a;
      MODE_T:  nxt = q ^ a;
      MODE_SR: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          default: nxt = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: D/T/SR/JK state bit plus its sticky invalid-SR flag.
module ff_cell
  import ff_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       clr_err,
  output logic       q,
  output logic       err
);

  logic q_d, q_q;
  logic err_d, err_q;

  // Next state; clr_err beats a coinciding invalid event and works even with en low.
  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (en) begin
      q_d = ff_next(mode, q_q, a, b);
    end else begin
      q_d = q_q;
    end
    if (clr_err) begin
      err_d = 1'b0;
    end else if (en && ff_invalid(mode, a, b)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q   = q_q;
  assign err = err_q;

endmodule

// File: rtl/ff_bank.sv
// WIDTH-channel flip-flop bank with shared mode and invalid-SR error reporting.
// Define FF_BANK_ERR_CNT_EN to add the saturating err_cnt port and counter.
module ff_bank
  import ff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err_vec,
  output logic             err_any
`ifdef FF_BANK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("ff_bank: WIDTH out of range 1..64");
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("ff_bank: CNT_W out of range 2..16");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    ff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .a       (a[gi]),
      .b       (b[gi]),
      .clr_err (clr_err),
      .q       (q[gi]),
      .err     (err_vec[gi])
    );
  end

  assign qb      = ~q;
  assign err_any = |err_vec;

`ifdef FF_BANK_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             inv_any_s;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // One count per edge with any invalid channel, saturating at all-ones.
  always_comb begin
    inv_any_s = (mode == MODE_SR) && (|(a & b));
    cnt_d     = cnt_q;
    if (clr_err) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en && inv_any_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

endmodule
